// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, loader state encoding and weight-count helper for the Conv1x1 weight loader
package conv_pkg;

    localparam int WEIGHT_W = 8;
    localparam int IDX_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CSUM = 2'd2,
        FIN  = 2'd3
    } loader_state_t;

    function automatic int total_weights(input int in_ch, input int out_ch);
        return in_ch * out_ch;
    endfunction

endpackage

// File: rtl/weight_index_counter.sv
// rtl/weight_index_counter.sv - nested (in, out) index counter; out wraps fastest, last flags the final pair
module weight_index_counter
    import conv_pkg::*;
#(
    parameter int INPUT_CHANNELS  = 64,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] idx_in,
    output logic [CNT_W-1:0] idx_out,
    output logic             last
);

    localparam logic [CNT_W-1:0] IN_MAX  = CNT_W'(INPUT_CHANNELS - 1);
    localparam logic [CNT_W-1:0] OUT_MAX = CNT_W'(OUTPUT_CHANNELS - 1);

    logic [CNT_W-1:0] idx_in_q, idx_in_d;
    logic [CNT_W-1:0] idx_out_q, idx_out_d;

    always_comb begin
        idx_in_d  = idx_in_q;
        idx_out_d = idx_out_q;
        if (clear) begin
            idx_in_d  = '0;
            idx_out_d = '0;
        end else if (inc) begin
            if (idx_out_q == OUT_MAX) begin
                idx_out_d = '0;
                idx_in_d  = (idx_in_q == IN_MAX) ? '0 : idx_in_q + 1'b1;
            end else begin
                idx_out_d = idx_out_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_in_q  <= '0;
            idx_out_q <= '0;
        end else begin
            idx_in_q  <= idx_in_d;
            idx_out_q <= idx_out_d;
        end
    end

    assign idx_in  = idx_in_q;
    assign idx_out = idx_out_q;
    assign last    = (idx_in_q == IN_MAX) && (idx_out_q == OUT_MAX);

endmodule

// File: rtl/conv1x1_weight_loader.sv
// rtl/conv1x1_weight_loader.sv - streams signed weight bytes into the Conv1x1 coefficient port; WEIGHT_CHECKSUM_EN adds a trailing checksum byte
module conv1x1_weight_loader #(
    parameter int INPUT_CHANNELS  = 64,
    parameter int OUTPUT_CHANNELS = 32,
    parameter int IDX_W           = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          s_valid,
    input  logic [conv_pkg::WEIGHT_W-1:0] s_data,
    output logic                          s_ready,
    output logic                          h_write,
    output logic [conv_pkg::WEIGHT_W-1:0] h_value,
    output logic [IDX_W-1:0]              h_index_in,
    output logic [IDX_W-1:0]              h_index_out,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    import conv_pkg::*;

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_LOAD = 2'(LOAD);
    localparam logic [1:0] S_FIN  = 2'(FIN);
`ifdef WEIGHT_CHECKSUM_EN
    localparam logic [1:0] S_CSUM = 2'(CSUM);
`endif

    logic [1:0]          state_q, state_d;
    logic                h_write_q, h_write_d;
    logic [WEIGHT_W-1:0] h_value_q, h_value_d;
    logic [IDX_W-1:0]    h_index_in_q, h_index_in_d;
    logic [IDX_W-1:0]    h_index_out_q, h_index_out_d;
    logic                cnt_clear, cnt_inc, cnt_last;
    logic [IDX_W-1:0]    cnt_in, cnt_out;
`ifdef WEIGHT_CHECKSUM_EN
    logic [WEIGHT_W-1:0] sum_q, sum_d;
    logic                err_q, err_d;
`endif

    weight_index_counter #(
        .INPUT_CHANNELS (INPUT_CHANNELS),
        .OUTPUT_CHANNELS(OUTPUT_CHANNELS),
        .CNT_W          (IDX_W)
    ) u_index (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .inc    (cnt_inc),
        .idx_in (cnt_in),
        .idx_out(cnt_out),
        .last   (cnt_last)
    );

    always_comb begin
        state_d       = state_q;
        h_write_d     = 1'b0;
        h_value_d     = h_value_q;
        h_index_in_d  = h_index_in_q;
        h_index_out_d = h_index_out_q;
        cnt_clear     = 1'b0;
        cnt_inc       = 1'b0;
`ifdef WEIGHT_CHECKSUM_EN
        sum_d         = sum_q;
        err_d         = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    cnt_clear = 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
                    sum_d     = '0;
                    err_d     = 1'b0;
`endif
                end
            end
            S_LOAD: begin
                // s_ready is constantly high here, so s_valid alone is the handshake
                if (s_valid) begin
                    h_write_d     = 1'b1;
                    h_value_d     = s_data;
                    h_index_in_d  = cnt_in;
                    h_index_out_d = cnt_out;
                    cnt_inc       = 1'b1;
`ifdef WEIGHT_CHECKSUM_EN
                    sum_d         = sum_q + s_data;
                    if (cnt_last) state_d = S_CSUM;
`else
                    if (cnt_last) state_d = S_FIN;
`endif
                end
            end
`ifdef WEIGHT_CHECKSUM_EN
            S_CSUM: begin
                if (s_valid) begin
                    err_d   = (s_data != sum_q);
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            h_write_q     <= 1'b0;
            h_value_q     <= '0;
            h_index_in_q  <= '0;
            h_index_out_q <= '0;
`ifdef WEIGHT_CHECKSUM_EN
            sum_q         <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            h_write_q     <= h_write_d;
            h_value_q     <= h_value_d;
            h_index_in_q  <= h_index_in_d;
            h_index_out_q <= h_index_out_d;
`ifdef WEIGHT_CHECKSUM_EN
            sum_q         <= sum_d;
            err_q         <= err_d;
`endif
        end
    end

`ifdef WEIGHT_CHECKSUM_EN
    assign s_ready = (state_q == S_LOAD) || (state_q == S_CSUM);
    assign err     = err_q;
`else
    assign s_ready = (state_q == S_LOAD);
    assign err     = 1'b0;
`endif
    assign busy        = s_ready;
    assign done        = (state_q == S_FIN);
    assign h_write     = h_write_q;
    assign h_value     = h_value_q;
    assign h_index_in  = h_index_in_q;
    assign h_index_out = h_index_out_q;

endmodule

// File: tb/tb_conv1x1_weight_loader.sv
// tb/tb_conv1x1_weight_loader.sv - scoreboard bench for conv1x1_weight_loader with a 2x3 index space
module tb_conv1x1_weight_loader;

    localparam int IC = 2;
    localparam int OC = 3;
`ifdef WEIGHT_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic       clk, reset, start, s_valid;
    logic [7:0] s_data;
    logic       s_ready, h_write, busy, done, err;
    logic [7:0] h_value, h_index_in, h_index_out;

    conv1x1_weight_loader #(
        .INPUT_CHANNELS (IC),
        .OUTPUT_CHANNELS(OC),
        .IDX_W          (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .h_write    (h_write),
        .h_value    (h_value),
        .h_index_in (h_index_in),
        .h_index_out(h_index_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] in_i;
        logic [7:0] out_i;
        logic [7:0] val;
        logic       dn;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int exp_k = 0;

    logic [7:0] v_basic [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [7:0] v_neg   [6] = '{8'h80, 8'hFF, 8'h7F, 8'h00, 8'h01, 8'hFE};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (done) done_cnt++;
        if (h_write) begin
            wr_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got write (%0d,%0d)=%0h expected none",
                         h_index_in, h_index_out, h_value);
            end else begin
                e = q.pop_front();
                check("h_index_in", h_index_in, e.in_i);
                check("h_index_out", h_index_out, e.out_i);
                check("h_value", h_value, e.val);
                check("write_latency", cyc, e.cyc);
                check("done_with_write", done, e.dn);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] b, input bit push);
        int   tries;
        exp_t e;
        tries   = 0;
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got s_ready=0 expected 1 within 50 cycles");
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            if (push) begin
                e.in_i  = 8'(exp_k / OC);
                e.out_i = 8'(exp_k % OC);
                e.val   = b;
                e.dn    = (exp_k == IC * OC - 1) && !CS;
                e.cyc   = cyc + 1;
                q.push_back(e);
                exp_k++;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_load(input logic [7:0] b [6], input int gap, input bit mid_start,
                            input logic [7:0] csum, input bit exp_err);
        int d0, w0;
        exp_k = 0;
        d0    = done_cnt;
        w0    = wr_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared_by_start", err, 0);
        for (int i = 0; i < 6; i++) begin
            send(b[i], 1'b1);
            if (gap > 0 && i < 5) begin
                s_valid = 1'b0;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_no_write", h_write, 0);
                    check("gap_index_hold", h_index_out, 32'((exp_k - 1) % OC));
                end
            end
            if (mid_start && i == 2) begin
                s_valid = 1'b0;
                start   = 1'b1;
                @(negedge clk);
                start   = 1'b0;
                check("busy_start_ignored", busy, 1);
            end
        end
        if (CS) begin
            check("no_done_before_csum", done, 0);
            send(csum, 1'b0);
        end
        check("done_pulse", done, 1);
        check("err_at_done", err, exp_err);
        check("busy_fin", busy, 0);
        check("s_ready_fin", s_ready, 0);
        s_valid = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("start_in_fin_ignored", busy, 0);
        check("s_ready_idle", s_ready, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("write_count", wr_cnt - w0, 6);
        check("done_count", done_cnt - d0, 1);
        check("scoreboard_empty", q.size(), 0);
    endtask

    initial begin
        reset   = 1'b0;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_h_write", h_write, 0);
        check("rst_outputs", {h_value, h_index_in, h_index_out}, 0);
        check("rst_flags", {busy, done, err}, 0);
        reset = 1'b1;
        @(negedge clk);

        run_load(v_basic, 0, 1'b0, 8'h15, 1'b0);

        // s_valid held high while idle must not be consumed
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("idle_s_ready", s_ready, 0);
        check("idle_no_write", wr_cnt, 6);
        run_load(v_basic, 2, 1'b0, 8'h15, 1'b0);

        run_load(v_neg, 0, 1'b0, 8'hFD, 1'b0);
        run_load(v_basic, 0, 1'b1, 8'h15, 1'b0);

        // asynchronous reset after the fourth byte
        exp_k = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) send(v_basic[i], 1'b1);
        s_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_flags", {s_ready, h_write, busy, done, err}, 0);
        check("async_rst_data", {h_value, h_index_in, h_index_out}, 0);
        check("async_rst_scoreboard", q.size(), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", busy, 0);
        run_load(v_basic, 0, 1'b0, 8'h15, 1'b0);

        run_load(v_basic, 1, 1'b0, 8'h16, CS);
        repeat (3) @(negedge clk);
        check("err_sticky", err, CS);
        run_load(v_basic, 0, 1'b0, 8'h15, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

endmodule
